hsv_core_ctrlstatus_arbiter: RTL

- Shares the single CSR register-block cpuif port between two requesters: index 0 is the pipeline readwrite unit, index 1 is the debug/external CSR access port.
- Allows one outstanding transaction at a time, arbitrates between the requesters, and routes each response back to its owner.
- Takes part in the global flush handshake: while a flush is in progress it blocks new pipeline grants, and it acknowledges only once no pipeline CSR access is in flight.

---
 rtl/hsv_core_pkg.sv | 13 +
 rtl/hsv_core_ctrlstatus_arbiter_if.sv | 28 ++
 rtl/hsv_core_ctrlstatus_arb_pick.sv | 20 ++
 rtl/hsv_core_ctrlstatus_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hsv_core_pkg.sv
// Shared core package: CSR arbiter state encoding and requester indices.
package hsv_core_pkg;

    typedef enum logic {
        ARB_IDLE     = 1'b0,
        ARB_WAIT_ACK = 1'b1
    } ctrlstatus_arb_state_t;

    // Requester indices into the packed m_* vectors.
    localparam logic ARB_REQ_PIPE = 1'b0;
    localparam logic ARB_REQ_DBG  = 1'b1;

endpackage

// File: rtl/hsv_core_ctrlstatus_arbiter_if.sv
// CSR register-block cpuif bus. The arbiter is the master; the register block is the slave.
interface hsv_core_ctrlstatus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req;
    logic                  req_is_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_biten;
    logic                  req_stall_wr;
    logic                  req_stall_rd;
    logic                  rd_ack;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_ack;
    logic                  wr_err;

    modport master (
        output req, req_is_wr, addr, wr_data, wr_biten,
        input  req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err
    );

    modport slave (
        input  req, req_is_wr, addr, wr_data, wr_biten,
        output req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err
    );
endinterface

// File: rtl/hsv_core_ctrlstatus_arb_pick.sv
// Two-way requester picker: fixed priority to requester 0, or alternate on ties.
module hsv_core_ctrlstatus_arb_pick #(
    parameter int PIPE_PRIORITY = 1
) (
    input  logic [1:0] eligible,
    input  logic       last_owner,
    output logic       sel,
    output logic       any
);

    // Ties go to index 0 in priority mode, otherwise to whoever did not own last.
    always_comb begin
        any = |eligible;
        sel = ~eligible[0];
        if (PIPE_PRIORITY == 0 && eligible == 2'b11) begin
            sel = ~last_owner;
        end
    end

endmodule

// File: rtl/hsv_core_ctrlstatus_arbiter.sv
// Shares the CSR cpuif port between the pipeline (index 0) and debug (index 1)
// requesters, one transaction outstanding at a time, and takes part in the
// global flush handshake.
// Optional ack watchdog: define HSV_CORE_CTRLSTATUS_ARB_TIMEOUT_EN.
//
// state        | meaning
// ARB_IDLE     | nothing outstanding; picked requester drives the bus
// ARB_WAIT_ACK | one transaction outstanding, waiting for its matching ack
module hsv_core_ctrlstatus_arbiter
    import hsv_core_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int PIPE_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    flush_req,
    output logic                    flush_ack,
    input  logic [1:0]              m_req,
    input  logic [1:0]              m_req_is_wr,
    input  logic [2*ADDR_WIDTH-1:0] m_addr,
    input  logic [2*DATA_WIDTH-1:0] m_wr_data,
    input  logic [2*DATA_WIDTH-1:0] m_wr_biten,
    output logic [1:0]              m_stall,
    output logic [1:0]              m_ack,
    output logic [1:0]              m_err,
    output logic [DATA_WIDTH-1:0]   m_rd_data,
    hsv_core_ctrlstatus_arbiter_if.master regs
);

    ctrlstatus_arb_state_t state;
    logic       owner;
    logic       owner_wr;
    logic       last_owner;
    logic [1:0] eligible;
    logic       sel;
    logic       any;
    logic       sel_wr;
    logic       idle;
    logic       waiting;
    logic       ds_stall;
    logic       accept;
    logic       cur_owner;
    logic       cur_wr;
    logic       ack_hit;
    logic       err_hit;
    logic       done_ack;
    logic       timeout;
    logic       resp;
    logic       pipe_busy;

    // A flush only holds off the pipeline; debug keeps being served.
    assign eligible = m_req & {1'b1, ~flush_req};

    hsv_core_ctrlstatus_arb_pick #(
        .PIPE_PRIORITY (PIPE_PRIORITY)
    ) u_pick (
        .eligible   (eligible),
        .last_owner (last_owner),
        .sel        (sel),
        .any        (any)
    );

    // Outputs are gated by reset so nothing leaks out while state is being cleared.
    assign idle    = (state == ARB_IDLE) && !rst_core;
    assign waiting = (state == ARB_WAIT_ACK) && !rst_core;

    assign sel_wr         = m_req_is_wr[sel];
    assign regs.req       = idle && any;
    assign regs.req_is_wr = sel_wr;
    assign regs.addr      = sel ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr[ADDR_WIDTH-1:0];
    assign regs.wr_data   = sel ? m_wr_data[2*DATA_WIDTH-1:DATA_WIDTH] : m_wr_data[DATA_WIDTH-1:0];
    assign regs.wr_biten  = sel ? m_wr_biten[2*DATA_WIDTH-1:DATA_WIDTH] : m_wr_biten[DATA_WIDTH-1:0];

    assign ds_stall = sel_wr ? regs.req_stall_wr : regs.req_stall_rd;
    assign accept   = regs.req && !ds_stall;

    // The transaction being answered is either the one accepted right now or the one owned.
    assign cur_owner = accept ? sel : owner;
    assign cur_wr    = accept ? sel_wr : owner_wr;
    assign ack_hit   = cur_wr ? regs.wr_ack : regs.rd_ack;
    assign err_hit   = cur_wr ? regs.wr_err : regs.rd_err;
    assign done_ack  = (accept || waiting) && ack_hit;
    assign resp      = done_ack || timeout;

    assign pipe_busy = (waiting && owner == ARB_REQ_PIPE) || (accept && sel == ARB_REQ_PIPE);

`ifdef HSV_CORE_CTRLSTATUS_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // to_cnt counts completed WAIT_ACK cycles; the watchdog fires on the cycle that reaches the limit.
    assign timeout = waiting && !ack_hit && (TO_W'(to_cnt + 1'b1) == TO_W'(TIMEOUT_CYCLES));

    // Watchdog counter: cleared on acceptance, advances while waiting.
    always_ff @(posedge clk_core) begin
        if (rst_core || accept) begin
            to_cnt <= '0;
        end else if (waiting) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // Watchdog compiled out: WAIT_ACK waits for the matching ack indefinitely.
    assign timeout = (TIMEOUT_CYCLES < 0) && 1'b0;
`endif

    // Per-requester stall, and the response routed back to the transaction owner.
    always_comb begin
        m_stall   = m_req;
        m_ack     = '0;
        m_err     = '0;
        m_rd_data = '0;
        if (accept) begin
            m_stall[sel] = 1'b0;
        end
        if (resp) begin
            m_ack[cur_owner] = 1'b1;
            m_err[cur_owner] = done_ack ? err_hit : 1'b1;
            if (done_ack && !cur_wr) begin
                m_rd_data = regs.rd_data;
            end
        end
    end

    // Arbiter FSM, owner tracking and registered flush acknowledge.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state      <= ARB_IDLE;
            owner      <= ARB_REQ_PIPE;
            owner_wr   <= 1'b0;
            last_owner <= ARB_REQ_DBG;
            flush_ack  <= 1'b0;
        end else begin
            flush_ack <= flush_req && !pipe_busy;
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        owner    <= sel;
                        owner_wr <= sel_wr;
                        if (ack_hit) begin
                            last_owner <= sel;
                        end else begin
                            state <= ARB_WAIT_ACK;
                        end
                    end
                end
                ARB_WAIT_ACK: begin
                    if (resp) begin
                        last_owner <= owner;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
